pipe_stage_reg: RTL

Parametrised pipeline stage register. It replaces the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block that adds:
- a valid/ready handshake for stall propagation;
- an optional skid entry so the upstream ready is registered;
- a synchronous flush that inserts a bubble.

Each stage boundary in the CPU instantiates one copy. Data and control fields are concatenated into two buses. Only the control bus is forced to zero on a bubble, which makes a bubble a NOP.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/pipe_entry.sv | 46 ++++
 rtl/pipe_stage_reg.sv | 119 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register:
// per-stage control widths, control field offsets, NOP constant and occupancy encoding.
package pipe_pkg;

    localparam int IF_ID_CTRL_W  = 8;
    localparam int ID_EX_CTRL_W  = 24;
    localparam int EX_MEM_CTRL_W = 12;
    localparam int MEM_WB_CTRL_W = 6;

    // Field offsets inside the ID/EX control bus
    localparam int CTRL_REG_WR_BIT = 0;
    localparam int CTRL_MEM_WR_BIT = 1;
    localparam int CTRL_MEM_RD_BIT = 2;
    localparam int CTRL_BRANCH_BIT = 3;
    localparam int CTRL_ALU_OP_LSB = 4;
    localparam int CTRL_ALU_OP_W   = 4;

    localparam int MAX_CTRL_W = 64;
    localparam logic [MAX_CTRL_W-1:0] NOP_CTRL = '0;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = EMPTY,
        ST_ONE   = ONE,
        ST_FULL  = FULL
    } stage_state_e;

endpackage

// File: rtl/pipe_entry.sv
// One held instruction: data + control register with load enable and synchronous clear.
// Control always clears; data only clears when CLEAR_DATA is set.
module pipe_entry #(
    parameter int DATA_W     = 96,
    parameter int CTRL_W     = 24,
    parameter int CLEAR_DATA = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            out_ctrl <= '0;
        else if (clear)
            out_ctrl <= '0;
        else if (load)
            out_ctrl <= in_ctrl;
    end

    generate
        if (CLEAR_DATA != 0) begin : g_clear
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    out_data <= '0;
                else if (clear)
                    out_data <= '0;
                else if (load)
                    out_data <= in_data;
            end
        end else begin : g_hold
            // No reset on the datapath: it only toggles when a new instruction lands
            always_ff @(posedge clk) begin
                if (load)
                    out_data <= in_data;
            end
        end
    endgenerate

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, optional skid entry
// and synchronous flush; a bubble always presents an all-zero (NOP) control bus.
import pipe_pkg::*;

module pipe_stage_reg #(
    parameter int DATA_W     = 96,
    parameter int CTRL_W     = 24,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    stage_state_e      state, state_nx;
    logic              ready_q;
    logic              accept, drain;
    logic              load_m, load_s, clr_m, clr_s, m_from_s;
    logic [DATA_W-1:0] m_data, s_data, m_d;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_c;

    assign out_valid = (state != ST_EMPTY);
    assign occupancy = state;
    assign in_ready  = (SKID != 0) ? ready_q : (ready_q & (out_ready | ~out_valid));
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;
    assign out_data  = m_data;
    assign out_ctrl  = out_valid ? m_ctrl : CTRL_W'(NOP_CTRL);
    assign m_d       = m_from_s ? s_data : in_data;
    assign m_c       = m_from_s ? s_ctrl : in_ctrl;

    // Flush wins: an accept in the same cycle is dropped, a drain already happened downstream
    always_comb begin
        state_nx = state;
        load_m   = 1'b0;
        load_s   = 1'b0;
        clr_m    = 1'b0;
        clr_s    = 1'b0;
        m_from_s = 1'b0;
        if (flush) begin
            state_nx = ST_EMPTY;
            clr_m    = 1'b1;
            clr_s    = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        load_m   = 1'b1;
                        state_nx = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        load_m = 1'b1;
                    end else if (accept && SKID != 0) begin
                        load_s   = 1'b1;
                        state_nx = ST_FULL;
                    end else if (drain && !accept) begin
                        clr_m    = 1'b1;
                        state_nx = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        load_m   = 1'b1;
                        m_from_s = 1'b1;
                        clr_s    = 1'b1;
                        state_nx = ST_ONE;
                    end
                end
                default: state_nx = ST_EMPTY;
            endcase
        end
    end

    // ready_q doubles as the "out of reset" flag when there is no skid entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nx;
            ready_q <= (state_nx != ST_FULL);
        end
    end

    pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(CLEAR_DATA)) u_main (
        .clk      (clk),
        .reset    (reset),
        .load     (load_m),
        .clear    (clr_m),
        .in_data  (m_d),
        .in_ctrl  (m_c),
        .out_data (m_data),
        .out_ctrl (m_ctrl)
    );

    pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(CLEAR_DATA)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .clear    (clr_s),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .out_data (s_data),
        .out_ctrl (s_ctrl)
    );

endmodule
